uart_hex_digit_rx: RTL and testbench

Serial front end for hex-digit entry. Receives 8N1 UART frames on one input line, holds the last good byte, and presents its hexadecimal digit value with a validity flag. Upstream logic collects successive digits into a multi-digit operand. A single `ready_out` strobe per good frame is the only handshake it needs.

---
 rtl/uart_hex_digit_rx.sv | 192 +++++++++++++++++++
 tb/tb_uart_hex_digit_rx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_digit_rx.sv
// ---------------------------------------------------------------------------
// uart_hex_digit_rx
//
// Serial front end for hex-digit entry. Receives 8N1 UART frames on rx and
// holds the last correctly framed byte. It also presents that byte's
// hexadecimal digit value, with a flag that says whether the byte is an
// ASCII hex digit at all.
//
// Parameters:
//   CLOCK_RATE  system clock frequency in Hz
//   BAUD_RATE   serial bit rate
//
// Ports:
//   clk          in   system clock, all logic on its rising edge
//   reset        in   synchronous active-high reset
//   rx           in   asynchronous serial line, idles high
//   data_out     out  [7:0] last correctly framed byte
//   ready_out    out  one-cycle strobe, data_out just updated
//   frame_error  out  one-cycle strobe, stop bit sampled low
//   hex_out      out  [3:0] hex value of data_out (0 when not a hex digit)
//   hex_valid    out  data_out is an ASCII hex digit
// ---------------------------------------------------------------------------
module uart_hex_digit_rx #(
    parameter int CLOCK_RATE = 100_000_000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       ready_out,
    output logic       frame_error,
    output logic [3:0] hex_out,
    output logic       hex_valid
);

    localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TIMER_W      = $clog2(CLKS_PER_BIT);

    localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(HALF_BIT - 1);

    // With fewer than four clocks per bit there is no usable mid-bit sample
    // point, so refuse to build at all.
    generate
        if (CLKS_PER_BIT < 4) begin : g_rate_check
            $error("uart_hex_digit_rx: CLOCK_RATE/BAUD_RATE must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t             state, state_next;
    logic [TIMER_W-1:0] timer, timer_next;
    logic [2:0]         bit_idx, bit_idx_next;
    logic [7:0]         shift_reg, shift_next;
    logic [7:0]         data_next;
    logic               ready_next;
    logic               frame_error_next;
    logic               sync1, sync2;
    logic               rxs;

    assign rxs = sync2;

    // Two-flop synchronizer for the asynchronous line. Both flops reset to
    // the idle level so that a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
        end
    end

    // Receiver state register. Everything the frame logic touches is
    // registered here so the strobes come out glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            data_out    <= '0;
            ready_out   <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            bit_idx     <= bit_idx_next;
            shift_reg   <= shift_next;
            data_out    <= data_next;
            ready_out   <= ready_next;
            frame_error <= frame_error_next;
        end
    end

    // Framing logic. The bit timer free-runs and is cleared at each sample
    // point, so START waits half a bit to land in the middle of the start
    // bit and every later sample lands one full bit further on. After a good
    // stop sample we drop straight back to IDLE without waiting out the rest
    // of the stop bit; that is what lets back-to-back frames through.
    always_comb begin
        state_next       = state;
        timer_next       = timer + 1'b1;
        bit_idx_next     = bit_idx;
        shift_next       = shift_reg;
        data_next        = data_out;
        ready_next       = 1'b0;
        frame_error_next = 1'b0;

        case (state)
            IDLE: begin
                timer_next = '0;
                if (!rxs) begin
                    state_next = START;
                end
            end

            START: begin
                if (timer == HALF_LAST) begin
                    timer_next   = '0;
                    bit_idx_next = '0;
                    state_next   = rxs ? IDLE : DATA;
                end
            end

            DATA: begin
                if (timer == BIT_LAST) begin
                    timer_next   = '0;
                    shift_next   = {rxs, shift_reg[7:1]};
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end

            STOP: begin
                if (timer == BIT_LAST) begin
                    timer_next = '0;
                    if (rxs) begin
                        data_next  = shift_reg;
                        ready_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_error_next = 1'b1;
                        state_next       = WAIT_IDLE;
                    end
                end
            end

            WAIT_IDLE: begin
                // A broken frame leaves the line low; wait for it to come
                // back up so the low level is not mistaken for a new start.
                timer_next = '0;
                if (rxs) begin
                    state_next = IDLE;
                end
            end

            default: begin
                timer_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    // ASCII hex decode of the held byte. Letters in either case map to
    // 10..15 by adding 9 to the low nibble ('A' = 0x41, 'a' = 0x61).
    always_comb begin
        hex_out   = 4'd0;
        hex_valid = 1'b0;
        if (data_out >= 8'h30 && data_out <= 8'h39) begin
            hex_out   = data_out[3:0];
            hex_valid = 1'b1;
        end else if ((data_out >= 8'h41 && data_out <= 8'h46) ||
                     (data_out >= 8'h61 && data_out <= 8'h66)) begin
            hex_out   = data_out[3:0] + 4'd9;
            hex_valid = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_hex_digit_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_hex_digit_rx
//
// Self-checking bench for uart_hex_digit_rx at CLOCK_RATE=16, BAUD_RATE=1
// (16 clocks per bit). Drives directed and randomized frames and compares
// the outputs with a reference model of the ASCII decode and framing rules.
// ---------------------------------------------------------------------------
module tb_uart_hex_digit_rx;

    localparam int CPB = 16;
    localparam int HB  = CPB / 2;
    // rx edge -> stop sample: two synchronizer cycles, one IDLE detect cycle,
    // half a bit, nine bits; the strobe appears right after that edge.
    localparam int READY_LATENCY = 3 + HB + 9 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data_out;
    logic       ready_out;
    logic       frame_error;
    logic [3:0] hex_out;
    logic       hex_valid;

    uart_hex_digit_rx #(
        .CLOCK_RATE(16),
        .BAUD_RATE (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data_out   (data_out),
        .ready_out  (ready_out),
        .frame_error(frame_error),
        .hex_out    (hex_out),
        .hex_valid  (hex_valid)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    // Observed strobes, collected by the monitor.
    logic [7:0]  got_data[$];
    logic [3:0]  got_hex[$];
    logic        got_valid[$];
    int unsigned got_cyc[$];
    int          rdy_count = 0;
    int          fe_count  = 0;
    logic        prev_ready = 1'b0;
    logic [7:0]  prev_data  = 8'h00;

    // Model state.
    int          exp_rdy = 0;
    int          exp_fe  = 0;
    logic [7:0]  exp_data = 8'h00;
    int unsigned start_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: {valid, value} straight from the ASCII ranges.
    function automatic logic [4:0] hex_model(input logic [7:0] b);
        int v;
        v = int'(b);
        if (v >= 48 && v <= 57)  return {1'b1, 4'(v - 48)};
        if (v >= 65 && v <= 70)  return {1'b1, 4'(v - 55)};
        if (v >= 97 && v <= 102) return {1'b1, 4'(v - 87)};
        return 5'b0_0000;
    endfunction

    // Monitor: records every strobe and checks the strobe/hold invariants.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (ready_out === 1'b1) begin
                got_data.push_back(data_out);
                got_hex.push_back(hex_out);
                got_valid.push_back(hex_valid);
                got_cyc.push_back(cyc);
                rdy_count++;
                check("ready_not_consecutive", 32'(prev_ready), 32'd0);
                check("ready_fe_exclusive", 32'(frame_error), 32'd0);
            end
            if (frame_error === 1'b1) fe_count++;
            check("data_held_between_ready",
                  32'((ready_out === 1'b1) || (data_out === prev_data)), 32'd1);
        end
        prev_ready = ready_out;
        prev_data  = data_out;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame; good=0 holds the stop bit low for two bit times.
    task automatic send_frame(input logic [7:0] b, input bit good);
        rx = 1'b0;
        start_cyc = cyc;
        wait_clk(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clk(CPB);
        end
        if (good) begin
            rx = 1'b1;
            wait_clk(CPB);
        end else begin
            rx = 1'b0;
            wait_clk(2 * CPB);
            rx = 1'b1;
            wait_clk(4);
        end
    endtask

    // Checks one expected good frame against the model.
    task automatic expect_good(input logic [7:0] b);
        logic [4:0] m;
        m = hex_model(b);
        check("ready_count", 32'(rdy_count), 32'(exp_rdy));
        check("ready_seen", 32'(got_data.size() > 0), 32'd1);
        if (got_data.size() > 0) begin
            check("strobe_data", 32'(got_data.pop_front()), 32'(b));
            check("strobe_hex", 32'(got_hex.pop_front()), 32'(m[3:0]));
            check("strobe_hex_valid", 32'(got_valid.pop_front()), 32'(m[4]));
            void'(got_cyc.pop_front());
        end
        check("data_out", 32'(data_out), 32'(b));
        check("hex_out", 32'(hex_out), 32'(m[3:0]));
        check("hex_valid", 32'(hex_valid), 32'(m[4]));
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_ready_count"}, 32'(rdy_count), 32'(exp_rdy));
        check({tag, "_fe_count"}, 32'(fe_count), 32'(exp_fe));
        check({tag, "_data_out"}, 32'(data_out), 32'(exp_data));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] b;
        bit         good;
        string      hexchars;
        hexchars = "0123456789abcdefABCDEF";

        // Reset and idle line.
        reset = 1'b1;
        rx    = 1'b1;
        wait_clk(3);
        check("reset_data_out", 32'(data_out), 32'h00);
        check("reset_ready", 32'(ready_out), 32'd0);
        check("reset_fe", 32'(frame_error), 32'd0);
        check("reset_hex_out", 32'(hex_out), 32'd0);
        check("reset_hex_valid", 32'(hex_valid), 32'd0);
        reset = 1'b0;
        wait_clk(50);
        check_counts("idle");
        check("idle_hex_valid", 32'(hex_valid), 32'd0);

        // '7' with latency check.
        send_frame(8'h37, 1'b1);
        exp_rdy++; exp_data = 8'h37;
        check("ready_latency",
              32'((got_cyc.size() > 0) ? (got_cyc[0] - start_cyc) : 0),
              32'(READY_LATENCY));
        expect_good(8'h37);
        wait_clk(10);

        // 'c' then 'F' back-to-back.
        send_frame(8'h63, 1'b1);
        exp_rdy++; exp_data = 8'h63;
        expect_good(8'h63);
        send_frame(8'h46, 1'b1);
        exp_rdy++; exp_data = 8'h46;
        expect_good(8'h46);
        wait_clk(10);

        // Non-hex bytes.
        send_frame(8'h47, 1'b1);
        exp_rdy++; exp_data = 8'h47;
        expect_good(8'h47);
        send_frame(8'h00, 1'b1);
        exp_rdy++; exp_data = 8'h00;
        expect_good(8'h00);
        wait_clk(10);

        // Short glitch is rejected as a false start.
        rx = 1'b0;
        wait_clk(3);
        rx = 1'b1;
        wait_clk(3 * CPB);
        check_counts("glitch");

        // Broken stop bit: one frame_error, data held.
        send_frame(8'h35, 1'b0);
        exp_fe++;
        wait_clk(CPB);
        check_counts("bad_stop");
        check("bad_stop_hex_valid", 32'(hex_valid), 32'd0);

        // Next frame after the error is received normally.
        send_frame(8'h39, 1'b1);
        exp_rdy++; exp_data = 8'h39;
        expect_good(8'h39);
        wait_clk(8);

        // Randomized frames against the model.
        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(1) == 0)
                b = hexchars[$urandom_range(hexchars.len() - 1)];
            else
                b = 8'($urandom_range(255));
            good = ($urandom_range(3) != 0);
            send_frame(b, good);
            if (good) begin
                exp_rdy++; exp_data = b;
                expect_good(b);
            end else begin
                exp_fe++;
                check_counts("rand_bad");
            end
            wait_clk(7 * $urandom_range(2));
        end
        check_counts("rand_end");

        // Reset in the middle of data bit 4.
        b = 8'h5A;
        rx = 1'b0;
        wait_clk(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            wait_clk(CPB);
        end
        rx = b[4];
        wait_clk(HB);
        reset = 1'b1;
        wait_clk(1);
        check("midreset_data_out", 32'(data_out), 32'h00);
        check("midreset_ready", 32'(ready_out), 32'd0);
        check("midreset_fe", 32'(frame_error), 32'd0);
        check("midreset_hex_out", 32'(hex_out), 32'd0);
        check("midreset_hex_valid", 32'(hex_valid), 32'd0);
        wait_clk(2);
        reset = 1'b0;
        rx    = 1'b1;
        exp_data = 8'h00;
        wait_clk(12 * CPB);
        check_counts("after_reset");

        send_frame(8'h41, 1'b1);
        exp_rdy++; exp_data = 8'h41;
        expect_good(8'h41);
        wait_clk(20);
        check_counts("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
